// File: rtl/apb_protocol_checker_pkg.sv
// Shared types and helpers for the APB protocol checker.
package apb_chk_pkg;

  // Bus phase, also used as the checker's expected-phase state.
  typedef enum logic [1:0] {
    PH_IDLE   = 2'd0,
    PH_SETUP  = 2'd1,
    PH_ACCESS = 2'd2
  } phase_e;

  // Violation codes; the value is also the bit index in err_flags.
  typedef enum logic [2:0] {
    ERR_SEL_MULTI   = 3'd0,
    ERR_EN_NO_SETUP = 3'd1,
    ERR_NO_ACCESS   = 3'd2,
    ERR_ACCESS_DROP = 3'd3,
    ERR_UNSTABLE    = 3'd4,
    ERR_TIMEOUT     = 3'd5,
    ERR_EN_HOLD     = 3'd6
  } err_code_e;

  localparam int NUM_ERR = 7;

  // Widest counter the saturating helper supports.
  localparam int SAT_W = 64;

  // Increment that sticks at max_val instead of wrapping.
  function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] val,
                                               input logic [SAT_W-1:0] max_val);
    return (val == max_val) ? val : val + 64'd1;
  endfunction

endpackage

// File: rtl/apb_protocol_checker_if.sv
// APB bus signal bundle. The checker only listens, so it uses the monitor view.
interface apb_chk_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SEL    = 4
);
  logic [NUM_SEL-1:0]      psel;
  logic                    penable;
  logic                    pwrite;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic                    pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata, pstrb,
    input  pready, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata, pstrb,
    output pready, pslverr
  );

  modport monitor (
    input psel, penable, pwrite, paddr, pwdata, pstrb, pready, pslverr
  );
endinterface

// File: rtl/apb_protocol_checker_wait_timer.sv
// Wait-state counter: counts enabled cycles, holds at TIMEOUT_CYCLES and
// raises expire on the single cycle where the count reaches the limit.
module apb_chk_wait_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic pclk,
  input  logic preset,
  input  logic clear,
  input  logic en,
  output logic expire
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST  = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_q, count_d;

  // Next count: clear dominates, otherwise count up and park at the limit.
  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (en && (count_q != LIMIT)) begin
      count_d = count_q + 1'b1;
    end
  end

  // Pulses only on the increment that lands on the limit, so one shot per run.
  assign expire = en && !clear && (count_q == LAST);

  // Count register.
  always_ff @(posedge pclk) begin
    if (preset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker: tracks the expected phase, flags protocol
// violations and keeps transfer/error statistics. Never drives the bus.
module apb_protocol_checker
  import apb_chk_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int NUM_SEL        = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                 pclk,
  input  logic                 preset,
  apb_chk_if.monitor           bus,
  input  logic                 clr,
  output logic                 err_valid,
  output logic [2:0]           err_code,
  output logic [NUM_ERR-1:0]   err_flags,
  output logic [CNT_WIDTH-1:0] xfer_cnt,
  output logic [CNT_WIDTH-1:0] err_cnt,
  output logic [CNT_WIDTH-1:0] slverr_cnt
);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  phase_e phase_obs;
  phase_e state_q, state_d;
  logic   wait_pending_q, wait_pending_d;

  logic [NUM_SEL-1:0]      cap_psel_q, cap_psel_d;
  logic                    cap_pwrite_q, cap_pwrite_d;
  logic [ADDR_WIDTH-1:0]   cap_paddr_q, cap_paddr_d;
  logic [DATA_WIDTH-1:0]   cap_pwdata_q, cap_pwdata_d;
  logic [DATA_WIDTH/8-1:0] cap_pstrb_q, cap_pstrb_d;

  logic                 err_valid_q, err_valid_d;
  logic [2:0]           err_code_q, err_code_d;
  logic [NUM_ERR-1:0]   err_flags_q, err_flags_d;
  logic [CNT_WIDTH-1:0] xfer_cnt_q, xfer_cnt_d;
  logic [CNT_WIDTH-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0] slverr_cnt_q, slverr_cnt_d;

  // chk holds every violation except the timeout, which depends on the
  // timer enable and therefore on chk itself.
  logic [NUM_ERR-1:0] chk;
  logic [NUM_ERR-1:0] viol;
  logic wait_active, fields_changed;
  logic in_xfer, recover, complete;
  logic timer_en, timer_clr, timer_expire;

  // Observed phase and the structural checks against the tracked state.
  always_comb begin
    phase_obs = PH_IDLE;
    if (|bus.psel) begin
      phase_obs = bus.penable ? PH_ACCESS : PH_SETUP;
    end
    wait_active    = (state_q == PH_ACCESS) && wait_pending_q;
    fields_changed = (bus.pwrite != cap_pwrite_q) ||
                     (bus.paddr  != cap_paddr_q)  ||
                     (bus.pstrb  != cap_pstrb_q)  ||
                     (cap_pwrite_q && (bus.pwdata != cap_pwdata_q));
    chk = '0;
    chk[ERR_SEL_MULTI]   = ($countones(bus.psel) > 1);
    chk[ERR_EN_NO_SETUP] = (state_q == PH_IDLE) && bus.penable;
    chk[ERR_NO_ACCESS]   = (state_q == PH_SETUP) &&
                           ((phase_obs != PH_ACCESS) || (bus.psel != cap_psel_q));
    chk[ERR_ACCESS_DROP] = wait_active && (phase_obs != PH_ACCESS);
    chk[ERR_UNSTABLE]    = wait_active && fields_changed;
    // Post-completion ACCESS state (no wait pending) means penable must drop.
    chk[ERR_EN_HOLD]     = (state_q == PH_ACCESS) && !wait_pending_q && bus.penable;
  end

  // Transfer progress; a timeout alone does not resync, so the timer holds.
  always_comb begin
    in_xfer   = (state_q == PH_SETUP) || wait_active;
    recover   = |chk;
    complete  = in_xfer && (phase_obs == PH_ACCESS) && bus.pready;
    timer_en  = in_xfer && (phase_obs == PH_ACCESS) && !bus.pready && !recover;
    timer_clr = !timer_en;
    viol = chk;
    viol[ERR_TIMEOUT] = timer_expire;
  end

  apb_chk_wait_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wait_timer (
    .pclk   (pclk),
    .preset (preset),
    .clear  (timer_clr),
    .en     (timer_en),
    .expire (timer_expire)
  );

  // Expected-phase FSM with resync to the observed phase on any violation.
  always_comb begin
    state_d = state_q;
    case (state_q)
      PH_IDLE:   state_d = (phase_obs == PH_SETUP) ? PH_SETUP : PH_IDLE;
      PH_SETUP:  state_d = PH_ACCESS;
      PH_ACCESS: state_d = wait_pending_q ? PH_ACCESS : phase_obs;
      default:   state_d = PH_IDLE;
    endcase
    if (recover) begin
      state_d = phase_obs;
    end
    wait_pending_d = (state_d == PH_ACCESS) && (phase_obs == PH_ACCESS) && !bus.pready;

    cap_psel_d   = cap_psel_q;
    cap_pwrite_d = cap_pwrite_q;
    cap_paddr_d  = cap_paddr_q;
    cap_pwdata_d = cap_pwdata_q;
    cap_pstrb_d  = cap_pstrb_q;
    if (state_d == PH_SETUP) begin
      cap_psel_d   = bus.psel;
      cap_pwrite_d = bus.pwrite;
      cap_paddr_d  = bus.paddr;
      cap_pwdata_d = bus.pwdata;
      cap_pstrb_d  = bus.pstrb;
    end
  end

  // Error reporting and statistics; clr beats a same-edge increment.
  always_comb begin
    err_valid_d = |viol;
    err_code_d  = 3'd0;
    for (int i = NUM_ERR - 1; i >= 0; i--) begin
      if (viol[i]) begin
        err_code_d = 3'(i);
      end
    end
    xfer_cnt_d = xfer_cnt_q;
    if (clr) begin
      xfer_cnt_d = '0;
    end else if (complete) begin
      xfer_cnt_d = CNT_WIDTH'(sat_inc(SAT_W'(xfer_cnt_q), SAT_W'(CNT_MAX)));
    end
    err_cnt_d = err_cnt_q;
    if (clr) begin
      err_cnt_d = '0;
    end else if (|viol) begin
      err_cnt_d = CNT_WIDTH'(sat_inc(SAT_W'(err_cnt_q), SAT_W'(CNT_MAX)));
    end
    slverr_cnt_d = slverr_cnt_q;
    if (complete && bus.pslverr) begin
      slverr_cnt_d = CNT_WIDTH'(sat_inc(SAT_W'(slverr_cnt_q), SAT_W'(CNT_MAX)));
    end
  end

  // Sticky flags, one per violation code.
  for (genvar gi = 0; gi < NUM_ERR; gi++) begin : g_flag
    assign err_flags_d[gi] = clr ? 1'b0 : (err_flags_q[gi] | viol[gi]);
  end

  // All state registers; reset abandons any transfer silently.
  always_ff @(posedge pclk) begin
    if (preset) begin
      state_q        <= PH_IDLE;
      wait_pending_q <= 1'b0;
      cap_psel_q     <= '0;
      cap_pwrite_q   <= 1'b0;
      cap_paddr_q    <= '0;
      cap_pwdata_q   <= '0;
      cap_pstrb_q    <= '0;
      err_valid_q    <= 1'b0;
      err_code_q     <= 3'd0;
      err_flags_q    <= '0;
      xfer_cnt_q     <= '0;
      err_cnt_q      <= '0;
      slverr_cnt_q   <= '0;
    end else begin
      state_q        <= state_d;
      wait_pending_q <= wait_pending_d;
      cap_psel_q     <= cap_psel_d;
      cap_pwrite_q   <= cap_pwrite_d;
      cap_paddr_q    <= cap_paddr_d;
      cap_pwdata_q   <= cap_pwdata_d;
      cap_pstrb_q    <= cap_pstrb_d;
      err_valid_q    <= err_valid_d;
      err_code_q     <= err_code_d;
      err_flags_q    <= err_flags_d;
      xfer_cnt_q     <= xfer_cnt_d;
      err_cnt_q      <= err_cnt_d;
      slverr_cnt_q   <= slverr_cnt_d;
    end
  end

  assign err_valid  = err_valid_q;
  assign err_code   = err_code_q;
  assign err_flags  = err_flags_q;
  assign xfer_cnt   = xfer_cnt_q;
  assign err_cnt    = err_cnt_q;
  assign slverr_cnt = slverr_cnt_q;
endmodule

// File: tb/tb_apb_protocol_checker.sv
// Directed bench for apb_protocol_checker (4-bit counters to reach saturation).
module tb_apb_protocol_checker;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 4;
  localparam int TO = 16;
  localparam int CW = 4;

  logic          pclk = 1'b0;
  logic          preset = 1'b1;
  logic          clr = 1'b0;
  logic          err_valid;
  logic [2:0]    err_code;
  logic [6:0]    err_flags;
  logic [CW-1:0] xfer_cnt, err_cnt, slverr_cnt;

  int         n_checks = 0;
  int         n_fail = 0;
  int         ev_count = 0;
  logic [2:0] ev_code = 3'd0;

  apb_chk_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SEL(NS)) bus_if ();

  apb_protocol_checker #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_SEL(NS),
    .TIMEOUT_CYCLES(TO), .CNT_WIDTH(CW)
  ) dut (
    .pclk(pclk), .preset(preset), .bus(bus_if.monitor), .clr(clr),
    .err_valid(err_valid), .err_code(err_code), .err_flags(err_flags),
    .xfer_cnt(xfer_cnt), .err_cnt(err_cnt), .slverr_cnt(slverr_cnt)
  );

  always #5 pclk = ~pclk;

  // Advance one edge and sample 1 ns later, logging any error pulse.
  task automatic tick();
    @(posedge pclk);
    #1;
    if (err_valid === 1'b1) begin
      ev_count++;
      ev_code = err_code;
    end
  endtask

  task automatic bus_idle();
    bus_if.psel = '0; bus_if.penable = 1'b0; bus_if.pready = 1'b0; bus_if.pslverr = 1'b0;
  endtask

  task automatic bus_setup(input logic [3:0] sel, input logic wr, input logic [31:0] addr,
                           input logic [31:0] data, input logic [3:0] strb);
    bus_if.psel = sel; bus_if.penable = 1'b0; bus_if.pwrite = wr; bus_if.paddr = addr;
    bus_if.pwdata = data; bus_if.pstrb = strb; bus_if.pready = 1'b0; bus_if.pslverr = 1'b0;
    $display("[%0t] setup sel=%b wr=%b addr=%h data=%h", $time, sel, wr, addr, data);
  endtask

  task automatic bus_access(input logic rdy, input logic err);
    bus_if.penable = 1'b1; bus_if.pready = rdy; bus_if.pslverr = err;
  endtask

  task automatic test_reset();
    preset = 1'b1; bus_idle(); tick(); tick();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL reset_err_valid: got %b exp 0", err_valid); end
    n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL reset_err_code: got %0d exp 0", err_code); end
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL reset_err_flags: got %b exp 0", err_flags); end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_xfer_cnt: got %0d exp 0", xfer_cnt); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d exp 0", err_cnt); end
    n_checks++; if (slverr_cnt !== 4'd0) begin n_fail++; $display("FAIL reset_slverr_cnt: got %0d exp 0", slverr_cnt); end
    preset = 1'b0;
  endtask

  task automatic test_legal();
    ev_count = 0;
    bus_setup(4'b0001, 1'b1, 32'h10, 32'hA5A5_A5A5, 4'hF); tick();
    bus_access(1'b0, 1'b0); tick(); tick();
    bus_access(1'b1, 1'b0); tick();
    bus_setup(4'b0001, 1'b0, 32'h10, 32'h0, 4'h0); tick();
    bus_access(1'b1, 1'b0); tick();
    bus_idle(); tick();
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL legal_flags: got %b exp 0", err_flags); end
    n_checks++; if (xfer_cnt !== 4'd2) begin n_fail++; $display("FAIL legal_xfer_cnt: got %0d exp 2", xfer_cnt); end
    n_checks++; if (ev_count !== 0) begin n_fail++; $display("FAIL legal_no_err_pulse: got %0d pulses exp 0", ev_count); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL legal_err_cnt: got %0d exp 0", err_cnt); end
  endtask

  task automatic test_sel_multi();
    bus_setup(4'b0101, 1'b1, 32'h10, 32'h1, 4'hF); tick();
    n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL selmulti_valid: got %b exp 1", err_valid); end
    n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL selmulti_code: got %0d exp 0", err_code); end
    n_checks++; if (err_flags !== 7'b0000001) begin n_fail++; $display("FAIL selmulti_flags: got %b exp 0000001", err_flags); end
    n_checks++; if (err_cnt !== 4'd1) begin n_fail++; $display("FAIL selmulti_err_cnt: got %0d exp 1", err_cnt); end
    // Abandoning SETUP while clearing: report the error, but clear wins.
    bus_idle(); clr = 1'b1; tick(); clr = 1'b0;
    n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL clrviol_valid: got %b exp 1", err_valid); end
    n_checks++; if (err_code !== 3'd2) begin n_fail++; $display("FAIL clrviol_code: got %0d exp 2", err_code); end
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL clrviol_flags: got %b exp 0", err_flags); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL clrviol_err_cnt: got %0d exp 0", err_cnt); end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL clrviol_xfer_cnt: got %0d exp 0", xfer_cnt); end
    tick();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL selmulti_pulse_end: got %b exp 0", err_valid); end
  endtask

  task automatic test_no_access();
    bus_setup(4'b0010, 1'b0, 32'h30, 32'h0, 4'h0); tick();
    bus_idle(); tick();
    n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL noacc_valid: got %b exp 1", err_valid); end
    n_checks++; if (err_code !== 3'd2) begin n_fail++; $display("FAIL noacc_code: got %0d exp 2", err_code); end
    n_checks++; if (err_flags !== 7'b0000100) begin n_fail++; $display("FAIL noacc_flags: got %b exp 0000100", err_flags); end
    n_checks++; if (err_cnt !== 4'd1) begin n_fail++; $display("FAIL noacc_err_cnt: got %0d exp 1", err_cnt); end
    ev_count = 0;
    bus_setup(4'b0010, 1'b0, 32'h34, 32'h0, 4'h0); tick();
    bus_access(1'b1, 1'b0); tick();
    bus_idle(); tick();
    n_checks++; if (ev_count !== 0) begin n_fail++; $display("FAIL noacc_resync_clean: got %0d pulses exp 0", ev_count); end
    n_checks++; if (xfer_cnt !== 4'd1) begin n_fail++; $display("FAIL noacc_xfer_cnt: got %0d exp 1", xfer_cnt); end
  endtask

  task automatic test_unstable();
    ev_count = 0;
    bus_setup(4'b0100, 1'b1, 32'h20, 32'h1234_5678, 4'hF); tick();
    bus_access(1'b0, 1'b0); tick();
    bus_if.paddr = 32'h24; tick();
    n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL unstable_valid: got %b exp 1", err_valid); end
    n_checks++; if (err_code !== 3'd4) begin n_fail++; $display("FAIL unstable_code: got %0d exp 4", err_code); end
    bus_if.paddr = 32'h20; tick();
    bus_access(1'b1, 1'b0); tick();
    bus_idle(); tick();
    n_checks++; if (ev_count !== 1) begin n_fail++; $display("FAIL unstable_pulses: got %0d exp 1", ev_count); end
    n_checks++; if (xfer_cnt !== 4'd2) begin n_fail++; $display("FAIL unstable_xfer_cnt: got %0d exp 2", xfer_cnt); end
    n_checks++; if (err_flags !== 7'b0010100) begin n_fail++; $display("FAIL unstable_flags: got %b exp 0010100", err_flags); end
    n_checks++; if (err_cnt !== 4'd2) begin n_fail++; $display("FAIL unstable_err_cnt: got %0d exp 2", err_cnt); end
  endtask

  task automatic test_timeout();
    int first_at;
    logic [2:0] code_seen;
    first_at = -1; code_seen = 3'd7; ev_count = 0;
    bus_setup(4'b0001, 1'b0, 32'h40, 32'h0, 4'h0); tick();
    bus_access(1'b0, 1'b0);
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (err_valid === 1'b1) begin
        if (first_at < 0) first_at = i;
        code_seen = err_code;
      end
    end
    n_checks++; if (ev_count !== 1) begin n_fail++; $display("FAIL timeout_pulses: got %0d exp 1", ev_count); end
    n_checks++; if (first_at !== 16) begin n_fail++; $display("FAIL timeout_edge: got %0d exp 16", first_at); end
    n_checks++; if (code_seen !== 3'd5) begin n_fail++; $display("FAIL timeout_code: got %0d exp 5", code_seen); end
    bus_access(1'b1, 1'b0); tick();
    bus_idle(); tick();
    n_checks++; if (xfer_cnt !== 4'd3) begin n_fail++; $display("FAIL timeout_xfer_cnt: got %0d exp 3", xfer_cnt); end
    n_checks++; if (err_flags !== 7'b0110100) begin n_fail++; $display("FAIL timeout_flags: got %b exp 0110100", err_flags); end
  endtask

  task automatic test_back_to_back();
    ev_count = 0;
    bus_setup(4'b1000, 1'b1, 32'h60, 32'hDEAD_BEEF, 4'hF); tick();
    bus_access(1'b1, 1'b1); tick();
    bus_setup(4'b1000, 1'b0, 32'h64, 32'h0, 4'h0); tick();
    bus_access(1'b1, 1'b0); tick();
    n_checks++; if (xfer_cnt !== 4'd5) begin n_fail++; $display("FAIL b2b_xfer_cnt: got %0d exp 5", xfer_cnt); end
    n_checks++; if (slverr_cnt !== 4'd1) begin n_fail++; $display("FAIL b2b_slverr_cnt: got %0d exp 1", slverr_cnt); end
    n_checks++; if (ev_count !== 0) begin n_fail++; $display("FAIL b2b_no_err_pulse: got %0d exp 0", ev_count); end
    tick();  // penable still high on the edge after completion
    n_checks++; if (err_valid !== 1'b1) begin n_fail++; $display("FAIL enhold_valid: got %b exp 1", err_valid); end
    n_checks++; if (err_code !== 3'd6) begin n_fail++; $display("FAIL enhold_code: got %0d exp 6", err_code); end
    n_checks++; if (err_cnt !== 4'd4) begin n_fail++; $display("FAIL enhold_err_cnt: got %0d exp 4", err_cnt); end
    bus_idle(); tick();
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL enhold_recover: got %b exp 0", err_valid); end
  endtask

  task automatic test_reset_mid();
    bus_setup(4'b0001, 1'b1, 32'h50, 32'h5555_AAAA, 4'hF); tick();
    bus_access(1'b0, 1'b0); tick(); tick();
    preset = 1'b1; tick();
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL rstmid_flags: got %b exp 0", err_flags); end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_xfer_cnt: got %0d exp 0", xfer_cnt); end
    n_checks++; if (slverr_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_slverr_cnt: got %0d exp 0", slverr_cnt); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL rstmid_err_cnt: got %0d exp 0", err_cnt); end
    bus_idle(); preset = 1'b0; ev_count = 0; tick(); tick();
    n_checks++; if (ev_count !== 0) begin n_fail++; $display("FAIL rstmid_no_abort_err: got %0d exp 0", ev_count); end
    bus_if.penable = 1'b1; tick();
    n_checks++; if (err_flags !== 7'b0000010) begin n_fail++; $display("FAIL ennosetup_flags: got %b exp 0000010", err_flags); end
    bus_if.penable = 1'b0; clr = 1'b1; tick(); clr = 1'b0;
    n_checks++; if (err_valid !== 1'b0) begin n_fail++; $display("FAIL clr_valid: got %b exp 0", err_valid); end
    n_checks++; if (err_code !== 3'd0) begin n_fail++; $display("FAIL clr_code: got %0d exp 0", err_code); end
    n_checks++; if (err_flags !== 7'd0) begin n_fail++; $display("FAIL clr_flags: got %b exp 0", err_flags); end
    n_checks++; if (err_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_err_cnt: got %0d exp 0", err_cnt); end
    n_checks++; if (xfer_cnt !== 4'd0) begin n_fail++; $display("FAIL clr_xfer_cnt: got %0d exp 0", xfer_cnt); end
  endtask

  task automatic test_saturate();
    ev_count = 0;
    for (int i = 0; i < 17; i++) begin
      bus_setup(4'b0001, 1'b0, 32'h70 + 32'(i), 32'h0, 4'h0); tick();
      bus_access(1'b1, 1'b0); tick();
    end
    bus_idle(); tick();
    n_checks++; if (xfer_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_xfer_cnt: got %0d exp 15", xfer_cnt); end
    n_checks++; if (ev_count !== 0) begin n_fail++; $display("FAIL sat_no_err_pulse: got %0d exp 0", ev_count); end
    bus_if.penable = 1'b1;
    for (int i = 0; i < 17; i++) tick();
    bus_idle(); tick();
    n_checks++; if (err_cnt !== 4'hF) begin n_fail++; $display("FAIL sat_err_cnt: got %0d exp 15", err_cnt); end
    n_checks++; if (ev_code !== 3'd1) begin n_fail++; $display("FAIL sat_err_code: got %0d exp 1", ev_code); end
  endtask

  initial begin
    bus_if.pwrite = 1'b0; bus_if.paddr = '0; bus_if.pwdata = '0; bus_if.pstrb = '0;
    bus_idle();
    test_reset();
    test_legal();
    test_sel_multi();
    test_no_access();
    test_unstable();
    test_timeout();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/apb_protocol_checker.md
# apb_protocol_checker

Synthesizable, parametrised APB protocol checker that passively observes one APB bus (master plus up to NUM_SEL slave selects). It tracks the IDLE/SETUP/ACCESS phase sequence, checks one-hot select, phase ordering, signal stability during wait states and a wait-state timeout. Violations are reported as registered error pulses, sticky flags and saturating counters. It sits beside the APB interconnect in both RTL and emulation builds, and has no effect on the bus.

## Interface
- ADDR_WIDTH, 32, paddr width
- DATA_WIDTH, 32, pwdata/prdata width; must be a multiple of 8
- NUM_SEL, 4, number of psel lines (≥1)
- TIMEOUT_CYCLES, 16, max wait cycles in ACCESS with pready=0 (≥1)
- CNT_WIDTH, 16, width of xfer_cnt/err_cnt

- pclk  in  1  APB clock; all logic on rising edge
- preset  in  1  synchronous reset, active-high
- psel  in  NUM_SEL  slave selects
- penable  in  1  enable
- pwrite  in  1  direction
- paddr  in  ADDR_WIDTH  address
- pwdata  in  DATA_WIDTH  write data
- pstrb  in  DATA_WIDTH/8  write strobes
- pready  in  1  slave ready (of selected slave, pre-muxed)
- pslverr  in  1  slave error
- clr  in  1  clears err_flags, err_cnt, xfer_cnt (synchronous)
- err_valid  out  1  one-cycle pulse: ≥1 violation sampled on previous edge
- err_code  out  3  lowest-numbered violation of that edge
- err_flags  out  7  sticky OR of all violations, bit i = code i
- xfer_cnt  out  CNT_WIDTH  completed transfers, saturating
- err_cnt  out  CNT_WIDTH  edges with ≥1 violation, saturating
- slverr_cnt  out  CNT_WIDTH  completed transfers with pslverr=1, saturating

## Operation
- Bus state sampled each edge: sel_any = |psel; phase = IDLE (!sel_any), SETUP (sel_any & !penable), ACCESS (sel_any & penable).
- FSM states IDLE, SETUP, ACCESS; tracks the expected phase:
  - IDLE → SETUP on sel_any & !penable; stays IDLE otherwise.
  - SETUP → ACCESS always; SETUP fields (psel, pwrite, paddr, pwdata, pstrb) are captured on entry to SETUP.
  - ACCESS with pready=0 → ACCESS; wait counter increments.
  - ACCESS with pready=1 → completion: xfer_cnt++, slverr_cnt++ if pslverr; next state IDLE or SETUP, according to the observed phase on the following edge.
- Violation codes (checked every edge, after reset):
  - 0 SEL_MULTI: more than one psel bit set.
  - 1 EN_NO_SETUP: penable=1 while FSM in IDLE.
  - 2 NO_ACCESS: FSM in SETUP and the observed phase is not ACCESS, or psel differs from the captured value.
  - 3 ACCESS_DROP: FSM in ACCESS with wait pending (previous pready=0) and the observed phase is not ACCESS.
  - 4 UNSTABLE: FSM in ACCESS, and pwrite, paddr, pstrb or (pwrite=1) pwdata differs from the captured value.
  - 5 TIMEOUT: wait counter reaches TIMEOUT_CYCLES; fires once per transfer.
  - 6 EN_HOLD: the edge after completion shows penable=1.
- Recovery: on any violation the FSM resynchronises to the observed phase, recaptures fields if that phase is SETUP, and clears the wait counter.
- clr and violation on the same edge: clear wins for counters and flags; err_valid/err_code still report the violation.

## Timing
- All outputs registered; a violation sampled at edge N appears at edge N+1.
- xfer_cnt/slverr_cnt update one edge after the completing edge.
- Wait counter width: $clog2(TIMEOUT_CYCLES+1). It holds at TIMEOUT_CYCLES until completion.
- Reset (preset=1): FSM IDLE, wait counter 0, every output 0. Reset mid-transfer abandons the transfer without error. The first edge after reset is checked against FSM IDLE.
- Counters saturate at all-ones and do not wrap.
- Zero-wait transfer: SETUP edge, then ACCESS edge with pready=1, so 2 edges per transfer. Back-to-back SETUP after completion is legal.

## Structure
- Package apb_chk_pkg: phase enum (IDLE, SETUP, ACCESS), err_code enum (7 values), NUM_ERR=7 constant, saturating-increment function.
- One sub-module, apb_chk_wait_timer: counter with clear/enable and a one-shot expiry pulse at TIMEOUT_CYCLES.

## Test plan
- Legal write, paddr=0x10, pwdata=0xA5A5_A5A5, 2 wait states, then legal read with 0 waits → err_flags=0, xfer_cnt=2, err_valid never set.
- psel=4'b0101 during SETUP → err_valid pulse next edge, err_code=0, err_flags[0]=1, err_cnt=1.
- SETUP followed by psel=0 → err_code=2; the FSM resyncs to IDLE, and the next legal transfer completes with no further errors.
- paddr changes from 0x20 to 0x24 during the second wait cycle → err_code=4; xfer_cnt still increments on completion.
- TIMEOUT_CYCLES=16 with pready held low for 20 cycles → exactly one err_code=5 pulse, 16 edges after ACCESS entry.
- preset asserted mid-ACCESS, then clr asserted with a pending sticky flag → all outputs 0 the edge after, and no error is reported for the aborted transfer.
